lcd1602_linegen: RTL and testbench
==================================

# lcd1602_linegen

Upstream text stage for the LCD1602 display path. Captures a 16-bit binary value on a load strobe and converts it to decimal with a sequential shift-add-3 (double-dabble) engine. Packs the result into two 16-character ASCII lines: decimal on line 1, hexadecimal on line 2. Its oLine1/oLine2 outputs drive the controller's line_rom1/line_rom2 inputs directly.

## Interface
- LABEL1, default "VAL: " (40 bits): 5-char prefix of line 1.
- LABEL2, default "HEX:0x" (48 bits): 6-char prefix of line 2.
- CLOCK  in  1  system clock, all logic on rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- iLoad  in  1  one-cycle request to capture iValue; honoured only in IDLE.
- iValue  in  16  unsigned binary value to display.
- oBusy  out  1  high while a conversion is in progress (state != IDLE).
- oValid  out  1  one-cycle pulse when oLine1/oLine2 have just updated.
- oLine1  out  128  line 1 ASCII; leftmost character in [127:120].
- oLine2  out  128  line 2 ASCII; leftmost character in [127:120].

## Operation
- States: IDLE, CONV, PACK.
- IDLE, iLoad=1:
  - capture iValue into a 16-bit shift register;
  - clear the 20-bit BCD register (5 nibbles) and the 4-bit shift counter;
  - go to CONV.
- IDLE, iLoad=0: hold.
- CONV, each cycle:
  - every BCD nibble >=5 gets +3;
  - then shift {bcd,bin} left by 1 and increment the counter.
  - After the 16th shift (counter==15 at that edge), go to PACK.
- PACK: register both lines, set oValid=1, go to IDLE. Exactly one cycle.
- iLoad in CONV or PACK: ignored, not queued. The line outputs keep their previous contents until PACK.
- Line 1 layout: LABEL1 (5 chars), then 5 decimal digits, then 6 x 0x20.
- Line 2 layout: LABEL2 (6 chars), then 4 hex digits MSB-first, then 6 x 0x20.
- Digit encoding:
  - decimal: 0x30+d;
  - hex: 0x30+n for n<10, 0x41+(n-10) for n>=10 (uppercase).
- Arithmetic: the BCD nibble add is 4-bit and cannot overflow, because 16 bits give at most 65535, which fits 5 digits. No saturation is needed.
- Reset values:
  - state IDLE;
  - oBusy=0, oValid=0;
  - oLine1 and oLine2 all 0x20 (128'h2020…20);
  - internal registers 0.
- Reset mid-operation: asynchronous return to all reset values. The aborted conversion never produces oValid.

## Timing
- iLoad sampled high at edge k (IDLE). Then:
  - CONV occupies edges k+1..k+16;
  - PACK happens at edge k+17;
  - lines and oValid update after edge k+17;
  - oValid drops after edge k+18.
- Latency: 17 cycles from iLoad sample to oValid. Throughput: one conversion per 18 cycles.
- oBusy is high from after edge k to after edge k+17. It is low in the oValid cycle.
- The earliest accepted next iLoad is the one sampled at edge k+18, coincident with oValid high. That is legal: oValid still falls, and the new conversion starts.
- oLine1/oLine2 are registered and stable between oValid pulses. The downstream controller can sample them at any time.

## Configuration
- LCD_LINEGEN_ZERO_BLANK_EN defined: leading zero decimal digits become 0x20. The least significant digit is always printed, so value 0 gives "    0". Blanking is computed in PACK with no added latency.
- Undefined: all 5 decimal digits are printed with leading zeros ("00000").
- The hex field is never blanked in either build.

## Structure
- Package lcd1602_pkg holds:
  - state enum {IDLE, CONV, PACK};
  - ASCII constants ASCII_SPACE=8'h20, ASCII_ZERO=8'h30, ASCII_A=8'h41;
  - nibble-to-hex-ASCII and nibble-to-decimal-ASCII functions.
- One sub-module, lcd1602_bin2bcd: a 16-bit to 5-digit double-dabble engine with start/done.
  - It owns the CONV counter and shift registers.
  - lcd1602_linegen keeps the FSM, the packing and the output registers.

## Test plan
- Reset: hold RST_n=0, then release -> oLine1=oLine2=16 x 0x20, oBusy=0, oValid=0 with no iLoad.
- iValue=12345, iLoad at edge k -> oValid high only after edge k+17. oLine1="VAL: 12345      ", oLine2="HEX:0x3039      ". oBusy high for exactly 17 cycles.
- iValue=0 -> with the macro, oLine1="VAL:     0      "; without it, "VAL: 00000      ". oLine2="HEX:0x0000      " in both builds.
- iValue=65535 -> oLine1="VAL: 65535      ", oLine2="HEX:0xFFFF      ".
- Busy rule: load 100, then pulse iLoad with 999 at k+5 -> result shows "00100"/"0x0064", with only one oValid. Then iLoad 999 in the oValid cycle -> accepted, and a second oValid follows 17 cycles later showing 999.
- Mid-op reset: load 4660, drop RST_n at k+8 -> outputs return to reset values immediately. No oValid occurs afterwards without a new iLoad.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// Shared types, ASCII constants and digit encoders for the LCD1602 text path.
package lcd1602_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    PACK
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    if (n < 4'd10)
      return ASCII_ZERO + {4'd0, n};
    else
      return ASCII_A + {4'd0, n - 4'd10};
  endfunction

  function automatic logic [7:0] nib2dec(input logic [3:0] n);
    return ASCII_ZERO + {4'd0, n};
  endfunction

endpackage

// File: rtl/lcd1602_bin2bcd.sv
// Sequential 16-bit to 5-digit BCD converter (shift-add-3), one shift per cycle.
module lcd1602_bin2bcd
  import lcd1602_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        start,
  input  logic [15:0] value,
  output logic [19:0] bcd,
  output logic        done
);

  logic [15:0] bin;
  logic [3:0]  cnt;
  logic        run;
  logic [19:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // done marks the cycle whose closing edge performs the 16th shift
  assign done = run && (cnt == 4'hF);

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      bin <= value;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      {bcd, bin} <= {adj[18:0], bin, 1'b0};
      cnt <= cnt + 4'd1;
      if (cnt == 4'hF)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd1602_linegen.sv
// Packs a 16-bit value into two ASCII lines (decimal, hex) for the LCD1602.
// Build option: LCD_LINEGEN_ZERO_BLANK_EN blanks leading decimal zeros.
module lcd1602_linegen
  import lcd1602_pkg::*;
#(
  parameter logic [39:0] LABEL1 = "VAL: ",
  parameter logic [47:0] LABEL2 = "HEX:0x"
) (
  input  logic         CLOCK,
  input  logic         RST_n,
  input  logic         iLoad,
  input  logic [15:0]  iValue,
  output logic         oBusy,
  output logic         oValid,
  output logic [127:0] oLine1,
  output logic [127:0] oLine2
);

  state_t        state, nstate;
  logic          start;
  logic          done;
  logic [15:0]   val_q;
  logic [19:0]   bcd;
  logic [39:0]   dec;
  logic [127:0]  line1_n, line2_n;

  lcd1602_bin2bcd u_bin2bcd (
    .CLOCK (CLOCK),
    .RST_n (RST_n),
    .start (start),
    .value (iValue),
    .bcd   (bcd),
    .done  (done)
  );

  always_comb begin
    nstate = state;
    start  = 1'b0;
    unique case (state)
      IDLE: if (iLoad) begin
        start  = 1'b1;
        nstate = CONV;
      end
      CONV: if (done) nstate = PACK;
      PACK: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
`ifdef LCD_LINEGEN_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    dec = {nib2dec(bcd[19:16]), nib2dec(bcd[15:12]),
           nib2dec(bcd[11:8]), nib2dec(bcd[7:4]),
           nib2dec(bcd[3:0])};
`ifdef LCD_LINEGEN_ZERO_BLANK_EN
    // units digit (i=0) is always printed
    for (int i = 4; i >= 1; i--) begin
      if (lead && bcd[4*i +: 4] == 4'd0)
        dec[8*i +: 8] = ASCII_SPACE;
      else
        lead = 1'b0;
    end
`endif
  end

  assign line1_n = {LABEL1, dec, {6{ASCII_SPACE}}};
  assign line2_n = {LABEL2,
                    nib2hex(val_q[15:12]), nib2hex(val_q[11:8]),
                    nib2hex(val_q[7:4]), nib2hex(val_q[3:0]),
                    {6{ASCII_SPACE}}};

  assign oBusy = (state != IDLE);

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state  <= IDLE;
      val_q  <= '0;
      oValid <= 1'b0;
      oLine1 <= {16{ASCII_SPACE}};
      oLine2 <= {16{ASCII_SPACE}};
    end else begin
      state  <= nstate;
      oValid <= (state == PACK);
      if (start)
        val_q <= iValue;
      if (state == PACK) begin
        oLine1 <= line1_n;
        oLine2 <= line2_n;
      end
    end
  end

endmodule

// File: tb/tb_lcd1602_linegen.sv
// Self-checking bench for lcd1602_linegen: reference model plus directed cases.
// Honours LCD_LINEGEN_ZERO_BLANK_EN for the expected decimal field.
module tb_lcd1602_linegen;

  logic         CLOCK = 1'b0;
  logic         RST_n = 1'b0;
  logic         iLoad = 1'b0;
  logic [15:0]  iValue = '0;
  logic         oBusy, oValid;
  logic [127:0] oLine1, oLine2;

  localparam logic [127:0] SP = {16{8'h20}};

  lcd1602_linegen dut (
    .CLOCK  (CLOCK),
    .RST_n  (RST_n),
    .iLoad  (iLoad),
    .iValue (iValue),
    .oBusy  (oBusy),
    .oValid (oValid),
    .oLine1 (oLine1),
    .oLine2 (oLine2)
  );

  always #5 CLOCK = ~CLOCK;

  int passed = 0;
  int total  = 0;
  int vcount = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [127:0] fmt1(input int v);
    logic [127:0] r;
    int pw[5] = '{10000, 1000, 100, 10, 1};
    int d;
    logic [7:0] ch;
    bit lead;
    r = SP;
    r[127:88] = "VAL: ";
    lead = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d  = (v / pw[i]) % 10;
      ch = 8'(8'h30 + d);
`ifdef LCD_LINEGEN_ZERO_BLANK_EN
      if (lead && d == 0 && i < 4) ch = 8'h20;
      else lead = 1'b0;
`endif
      r[87-8*i -: 8] = ch;
    end
    return r;
  endfunction

  function automatic logic [127:0] fmt2(input int v);
    logic [127:0] r;
    int n;
    r = SP;
    r[127:80] = "HEX:0x";
    for (int i = 0; i < 4; i++) begin
      n = (v >> (12 - 4*i)) & 15;
      r[79-8*i -: 8] = (n < 10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 10);
    end
    return r;
  endfunction

  // Model: a request accepted while idle yields its lines 17 edges later
  int           rem;
  logic [15:0]  pend;
  logic [127:0] m1, m2;
  logic         mvalid;

  always @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      rem = 0; m1 = SP; m2 = SP; mvalid = 1'b0; pend = '0;
    end else begin
      mvalid = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m1 = fmt1(int'(pend));
          m2 = fmt2(int'(pend));
          mvalid = 1'b1;
        end
      end else if (iLoad) begin
        pend = iValue;
        rem  = 17;
      end
    end
  end

  always @(negedge CLOCK) begin
    check("busy", {127'd0, oBusy}, {127'd0, rem > 0});
    check("valid", {127'd0, oValid}, {127'd0, mvalid});
    check("line1", oLine1, m1);
    check("line2", oLine2, m2);
    if (oValid) vcount++;
  end

  task automatic do_load(input logic [15:0] v);
    @(negedge CLOCK); #1;
    iLoad = 1'b1; iValue = v;
    @(negedge CLOCK); #1;
    iLoad = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int nb);
    lat = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (oBusy) nb++;
      if (oValid) break;
      @(negedge CLOCK); #1;
      lat++;
    end
    check("valid_timeout", {127'd0, oValid}, 128'd1);
  endtask

  int lat, nb, v0;

  initial begin
    repeat (3) @(negedge CLOCK);
    #1;
    check("rst_line1", oLine1, SP);
    check("rst_line2", oLine2, SP);
    RST_n = 1'b1;
    repeat (2) @(negedge CLOCK);
    #1;
    check("idle_busy", {127'd0, oBusy}, 128'd0);
    check("idle_valid", {127'd0, oValid}, 128'd0);
    check("idle_line1", oLine1, SP);

    do_load(16'd12345);
    wait_valid(lat, nb);
    check("lat_12345", lat, 17);
    check("busy_12345", nb, 17);
    check("l1_12345", oLine1, "VAL: 12345      ");
    check("l2_12345", oLine2, "HEX:0x3039      ");
    check("busy_in_valid", {127'd0, oBusy}, 128'd0);

    do_load(16'd0);
    wait_valid(lat, nb);
`ifdef LCD_LINEGEN_ZERO_BLANK_EN
    check("l1_0", oLine1, "VAL:     0      ");
`else
    check("l1_0", oLine1, "VAL: 00000      ");
`endif
    check("l2_0", oLine2, "HEX:0x0000      ");

    do_load(16'd65535);
    wait_valid(lat, nb);
    check("l1_ffff", oLine1, "VAL: 65535      ");
    check("l2_ffff", oLine2, "HEX:0xFFFF      ");

    v0 = vcount;
    do_load(16'd100);
    repeat (4) @(negedge CLOCK);
    #1;
    iLoad = 1'b1; iValue = 16'd999;
    @(negedge CLOCK); #1;
    iLoad = 1'b0;
    wait_valid(lat, nb);
`ifdef LCD_LINEGEN_ZERO_BLANK_EN
    check("l1_100", oLine1, "VAL:   100      ");
`else
    check("l1_100", oLine1, "VAL: 00100      ");
`endif
    check("l2_100", oLine2, "HEX:0x0064      ");
    check("one_valid", vcount - v0, 1);
    iLoad = 1'b1; iValue = 16'd999;
    @(negedge CLOCK); #1;
    iLoad = 1'b0;
    wait_valid(lat, nb);
    check("lat_999", lat, 17);
`ifdef LCD_LINEGEN_ZERO_BLANK_EN
    check("l1_999", oLine1, "VAL:   999      ");
`else
    check("l1_999", oLine1, "VAL: 00999      ");
`endif
    check("l2_999", oLine2, "HEX:0x03E7      ");
    check("two_valid", vcount - v0, 2);

    do_load(16'd4660);
    repeat (7) @(negedge CLOCK);
    #1;
    RST_n = 1'b0;
    #1;
    check("mid_busy", {127'd0, oBusy}, 128'd0);
    check("mid_valid", {127'd0, oValid}, 128'd0);
    check("mid_line1", oLine1, SP);
    check("mid_line2", oLine2, SP);
    v0 = vcount;
    @(negedge CLOCK); #1;
    RST_n = 1'b1;
    repeat (30) @(negedge CLOCK);
    #1;
    check("no_valid_after_rst", vcount - v0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
